// File: rtl/mini_proc_run_ctrl.sv
// mini_proc_run_ctrl
// Run controller for the single-cycle mini processor: gates the core through
// a clock-enable, stops on a cycle limit or PC breakpoint, supports
// single-step/resume, and records every register/memory write into a
// circular trace FIFO drained over a valid/ready port.
module mini_proc_run_ctrl #(
   parameter int DATA_W = 8,
   parameter int PC_W   = 8,
   parameter int CYC_W  = 16,
   parameter int DEPTH  = 16
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_start,
   input  logic                              i_resume,
   input  logic                              i_step,
   input  logic [CYC_W-1:0]                  i_max_cycles,
   input  logic                              i_bp_en,
   input  logic [PC_W-1:0]                   i_bp_pc,
   input  logic [PC_W-1:0]                   i_pc,
   input  logic                              i_reg_write,
   input  logic                              i_mem_write,
   input  logic [DATA_W-1:0]                 i_wb_data,
   input  logic [DATA_W-1:0]                 i_mem_data,
   output logic                              o_cpu_en,
   output logic                              o_running,
   output logic                              o_halted,
   output logic [1:0]                        o_halt_cause,
   output logic [CYC_W-1:0]                  o_cycle_count,
   output logic                              o_tr_valid,
   output logic [CYC_W+2+PC_W+DATA_W-1:0]    o_tr_data,
   input  logic                              i_tr_ready,
   output logic [$clog2(DEPTH):0]            o_tr_count,
   output logic                              o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = CYC_W + 2 + PC_W + DATA_W;
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_HALT = 2'b11
   } state_t;

   localparam logic [1:0] C_CAUSE_NONE  = 2'b00;
   localparam logic [1:0] C_CAUSE_LIMIT = 2'b01;
   localparam logic [1:0] C_CAUSE_BP    = 2'b10;
   localparam logic [1:0] C_CAUSE_STEP  = 2'b11;

   state_t            r_state;
   logic              r_skip_bp;
   logic [1:0]        r_cause;
   logic [CYC_W-1:0]  r_cycle_count;

   logic [EW-1:0]     r_mem [DEPTH];
   logic [AW-1:0]     r_rd_ptr;
   logic [AW-1:0]     r_wr_ptr;
   logic [AW:0]       r_count;
   logic              r_overflow;
   logic [EW-1:0]     r_tr_data;

   logic              w_bp_hit;
   logic              w_cpu_en;
   logic [CYC_W-1:0]  w_cnt_inc;
   logic              w_cnt_sat;
   logic              w_limit_hit;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic [EW-1:0]     w_entry;
   logic [AW-1:0]     w_rd_nxt;
   logic [AW:0]       w_count_nxt;
   logic              w_ovf_set;
   logic [EW-1:0]     w_head_nxt;

   // The breakpoint is skipped for the first RUN cycle after a resume so the
   // halted-on instruction can execute.
   assign w_bp_hit    = i_bp_en & (i_pc == i_bp_pc) & (r_state == S_RUN) & ~r_skip_bp;
   assign w_cnt_inc   = r_cycle_count + CYC_W'(1'b1);
   assign w_cnt_sat   = &r_cycle_count;
   assign w_limit_hit = (i_max_cycles != '0) && (w_cnt_inc == i_max_cycles);

   // Clock-enable to the core: must react to the PC in the same cycle.
   always_comb begin
      w_cpu_en = 1'b0;
      case (r_state)
         S_STEP:  w_cpu_en = 1'b1;
         S_RUN:   w_cpu_en = ~w_bp_hit;
         default: w_cpu_en = 1'b0;
      endcase
   end

   // Run-control FSM, halt cause and saturating enabled-cycle counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_skip_bp     <= 1'b0;
         r_cause       <= C_CAUSE_NONE;
         r_cycle_count <= '0;
      end else if (i_start) begin
         r_state       <= S_RUN;
         r_skip_bp     <= 1'b0;
         r_cause       <= C_CAUSE_NONE;
         r_cycle_count <= '0;
      end else begin
         if (w_cpu_en && !w_cnt_sat) begin
            r_cycle_count <= w_cnt_inc;
         end
         case (r_state)
            S_IDLE: begin
               r_state <= S_IDLE;
            end
            S_RUN: begin
               r_skip_bp <= 1'b0;
               if (w_bp_hit) begin
                  r_state <= S_HALT;
                  r_cause <= C_CAUSE_BP;
               end else if (w_limit_hit) begin
                  r_state <= S_HALT;
                  r_cause <= C_CAUSE_LIMIT;
               end
            end
            S_STEP: begin
               r_state <= S_HALT;
               r_cause <= C_CAUSE_STEP;
            end
            S_HALT: begin
               if (i_resume) begin
                  r_state   <= S_RUN;
                  r_skip_bp <= 1'b1;
                  r_cause   <= C_CAUSE_NONE;
               end else if (i_step) begin
                  r_state <= S_STEP;
                  r_cause <= C_CAUSE_NONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_push  = w_cpu_en & (i_reg_write | i_mem_write);
   assign w_pop   = (r_count != '0) & i_tr_ready;
   assign w_full  = (r_count == C_FULL);
   assign w_entry = {r_cycle_count, i_mem_write, i_reg_write, i_pc,
                     (i_reg_write ? i_wb_data : i_mem_data)};

   // Next read pointer / occupancy; a push into a full FIFO drops the oldest.
   always_comb begin
      w_rd_nxt    = r_rd_ptr;
      w_count_nxt = r_count;
      w_ovf_set   = 1'b0;
      if (w_push && w_pop) begin
         w_rd_nxt = r_rd_ptr + AW'(1'b1);
      end else if (w_push) begin
         if (w_full) begin
            w_rd_nxt  = r_rd_ptr + AW'(1'b1);
            w_ovf_set = 1'b1;
         end else begin
            w_count_nxt = r_count + (AW+1)'(1'b1);
         end
      end else if (w_pop) begin
         w_rd_nxt    = r_rd_ptr + AW'(1'b1);
         w_count_nxt = r_count - (AW+1)'(1'b1);
      end else begin
         w_rd_nxt = r_rd_ptr;
      end
   end

   // The next head comes from the bypass when it is the slot being written now.
   assign w_head_nxt = (w_push && (w_rd_nxt == r_wr_ptr)) ? w_entry : r_mem[w_rd_nxt];

   // Trace storage array; no reset needed since occupancy qualifies reads.
   always_ff @(posedge i_clk) begin
      if (w_push && !i_start) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   // FIFO pointers, occupancy, sticky overflow and the registered head entry.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tr_data  <= '0;
      end else if (i_start) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tr_data  <= '0;
      end else begin
         r_rd_ptr  <= w_rd_nxt;
         r_count   <= w_count_nxt;
         r_tr_data <= w_head_nxt;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1'b1);
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_cpu_en      = w_cpu_en;
   assign o_running     = (r_state == S_RUN) || (r_state == S_STEP);
   assign o_halted      = (r_state == S_HALT);
   assign o_halt_cause  = r_cause;
   assign o_cycle_count = r_cycle_count;
   assign o_tr_valid    = (r_count != '0);
   assign o_tr_data     = r_tr_data;
   assign o_tr_count    = r_count;
   assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_mini_proc_run_ctrl.sv
// Self-checking bench for mini_proc_run_ctrl: directed scenarios plus a
// randomized run against a queue-based behavioural model.
module tb_mini_proc_run_ctrl;
   localparam int DATA_W = 8;
   localparam int PC_W   = 8;
   localparam int CYC_W  = 16;
   localparam int DEPTH  = 16;
   localparam int EW     = CYC_W + 2 + PC_W + DATA_W;

   logic clk = 1'b0;
   logic rst, start, resume, step, bp_en, reg_write, mem_write, tr_ready;
   logic [CYC_W-1:0] max_cycles;
   logic [PC_W-1:0]  bp_pc, pc;
   logic [DATA_W-1:0] wb_data, mem_data;
   logic cpu_en, running, halted, tr_valid, overflow;
   logic [1:0] halt_cause;
   logic [CYC_W-1:0] cycle_count;
   logic [EW-1:0] tr_data;
   logic [$clog2(DEPTH):0] tr_count;

   always #5 clk = ~clk;

   mini_proc_run_ctrl #(.DATA_W(DATA_W), .PC_W(PC_W), .CYC_W(CYC_W), .DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_resume(resume), .i_step(step),
      .i_max_cycles(max_cycles), .i_bp_en(bp_en), .i_bp_pc(bp_pc), .i_pc(pc),
      .i_reg_write(reg_write), .i_mem_write(mem_write), .i_wb_data(wb_data),
      .i_mem_data(mem_data), .o_cpu_en(cpu_en), .o_running(running), .o_halted(halted),
      .o_halt_cause(halt_cause), .o_cycle_count(cycle_count), .o_tr_valid(tr_valid),
      .o_tr_data(tr_data), .i_tr_ready(tr_ready), .o_tr_count(tr_count), .o_overflow(overflow)
   );

   int checks = 0;
   int failures = 0;

   // Behavioural model: 0 idle, 1 run, 2 step, 3 halt
   int m_state, m_cnt, m_cause;
   bit m_skip, m_ovf, auto_pc;
   logic [EW-1:0] m_q[$];

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_cause = 0; m_skip = 0; m_ovf = 0;
      m_q.delete();
   endtask

   function automatic bit exp_en();
      bit bphit;
      bphit = bp_en && (pc == bp_pc) && !m_skip;
      return (m_state == 2) || (m_state == 1 && !bphit);
   endfunction

   // One clock: snapshot inputs, advance DUT and model, return at negedge.
   task automatic tick();
      bit en, pop, bphit, lim;
      logic [EW-1:0] e;
      en    = exp_en();
      bphit = bp_en && (pc == bp_pc) && !m_skip && (m_state == 1);
      pop   = (m_q.size() != 0) && tr_ready;
      lim   = (max_cycles != 0) && (((m_cnt + 1) & 32'hFFFF) == int'(max_cycles));
      e     = {CYC_W'(m_cnt), mem_write, reg_write, pc, (reg_write ? wb_data : mem_data)};
      @(posedge clk);
      if (start) begin
         m_state = 1; m_cnt = 0; m_cause = 0; m_skip = 0; m_ovf = 0;
         m_q.delete();
      end else begin
         if (pop) void'(m_q.pop_front());
         if (en && (reg_write || mem_write)) begin
            m_q.push_back(e);
            if (m_q.size() > DEPTH) begin
               void'(m_q.pop_front());
               m_ovf = 1;
            end
         end
         if (en && m_cnt != 65535) m_cnt = m_cnt + 1;
         case (m_state)
            1: begin
               if (bphit) begin m_state = 3; m_cause = 2; end
               else if (lim) begin m_state = 3; m_cause = 1; end
               m_skip = 0;
            end
            2: begin m_state = 3; m_cause = 3; end
            3: begin
               if (resume) begin m_state = 1; m_skip = 1; m_cause = 0; end
               else if (step) begin m_state = 2; m_cause = 0; end
            end
            default: ;
         endcase
      end
      @(negedge clk);
      if (auto_pc && en) pc = pc + 8'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; resume = 0; step = 0; bp_en = 0; reg_write = 0; mem_write = 0;
      tr_ready = 0; max_cycles = 0; bp_pc = 0; pc = 0; wb_data = 0; mem_data = 0; auto_pc = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL rst_cpu_en got=%0b exp=0", cpu_en); end
      checks++; if ({running, halted, halt_cause} !== 4'b0) begin failures++; $display("FAIL rst_state got=%b exp=0000", {running, halted, halt_cause}); end
      checks++; if (cycle_count !== 16'd0 || tr_count !== 5'd0 || tr_valid !== 1'b0 || overflow !== 1'b0) begin
         failures++; $display("FAIL rst_counts cyc=%0d cnt=%0d v=%0b ovf=%0b exp all 0", cycle_count, tr_count, tr_valid, overflow); end
      checks++; if (tr_data !== '0) begin failures++; $display("FAIL rst_tr_data got=%h exp=0", tr_data); end
      resume = 1; step = 1;
      tick(); tick();
      resume = 0; step = 0;
      checks++; if (running !== 1'b0 || halted !== 1'b0 || cpu_en !== 1'b0) begin
         failures++; $display("FAIL idle_ignore run=%0b halt=%0b en=%0b exp 0", running, halted, cpu_en); end
   endtask

   task automatic test_limit();
      int n;
      n = 0;
      max_cycles = 16'd5; bp_en = 0;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 12; i++) begin
         #1; if (cpu_en === 1'b1) n++;
         tick();
      end
      checks++; if (n != 5) begin failures++; $display("FAIL limit_en_cycles got=%0d exp=5", n); end
      checks++; if (halted !== 1'b1 || halt_cause !== 2'b01) begin failures++; $display("FAIL limit_halt halted=%0b cause=%b exp 1/01", halted, halt_cause); end
      checks++; if (cycle_count !== 16'd5) begin failures++; $display("FAIL limit_count got=%0d exp=5", cycle_count); end
   endtask

   task automatic test_breakpoint();
      max_cycles = 0; bp_en = 1; bp_pc = 8'h03; pc = 0; auto_pc = 1;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (halted === 1'b1) break;
         if (pc == 8'h03) begin
            checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL bp_en_drop got=%0b exp=0", cpu_en); end
         end
         tick();
      end
      checks++; if (halted !== 1'b1 || halt_cause !== 2'b10) begin failures++; $display("FAIL bp_halt halted=%0b cause=%b exp 1/10", halted, halt_cause); end
      checks++; if (cycle_count !== 16'd3 || pc !== 8'h03) begin failures++; $display("FAIL bp_count cyc=%0d pc=%0d exp 3/3", cycle_count, pc); end
      resume = 1; tick(); resume = 0;
      #1;
      checks++; if (cpu_en !== 1'b1) begin failures++; $display("FAIL resume_exec got=%0b exp=1", cpu_en); end
      tick();
      checks++; if (cycle_count !== 16'd4 || pc !== 8'h04 || running !== 1'b1) begin
         failures++; $display("FAIL resume_continue cyc=%0d pc=%0d run=%0b exp 4/4/1", cycle_count, pc, running); end
      bp_en = 0; auto_pc = 0;
   endtask

   task automatic test_step();
      max_cycles = 16'd2;
      start = 1; tick(); start = 0;
      for (int i = 0; i < 10 && halted !== 1'b1; i++) tick();
      for (int k = 0; k < 3; k++) begin
         step = 1; tick(); step = 0;
         #1;
         checks++; if (cpu_en !== 1'b1 || running !== 1'b1) begin failures++; $display("FAIL step_en k=%0d en=%0b run=%0b exp 1/1", k, cpu_en, running); end
         tick();
         checks++; if (halted !== 1'b1 || halt_cause !== 2'b11 || cpu_en !== 1'b0) begin
            failures++; $display("FAIL step_done k=%0d halted=%0b cause=%b en=%0b exp 1/11/0", k, halted, halt_cause, cpu_en); end
      end
      checks++; if (cycle_count !== 16'd5) begin failures++; $display("FAIL step_count got=%0d exp=5", cycle_count); end
   endtask

   task automatic test_overflow();
      logic [CYC_W-1:0] c;
      max_cycles = 0; bp_en = 0; tr_ready = 0;
      start = 1; tick(); start = 0;
      reg_write = 1;
      for (int i = 0; i < 20; i++) begin wb_data = 8'($urandom); tick(); end
      reg_write = 0;
      c = tr_data[EW-1 -: CYC_W];
      checks++; if (tr_count !== 5'd16 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_full cnt=%0d ovf=%0b exp 16/1", tr_count, overflow); end
      checks++; if (c !== 16'd4) begin failures++; $display("FAIL ovf_oldest_cycle got=%0d exp=4", c); end
      checks++; if (tr_data !== m_q[0]) begin failures++; $display("FAIL ovf_head got=%h exp=%h", tr_data, m_q[0]); end
   endtask

   task automatic test_kind_and_full_pushpop();
      logic [EW-1:0] h;
      tr_ready = 0;
      start = 1; tick(); start = 0;
      reg_write = 1;
      for (int i = 0; i < 16; i++) begin wb_data = 8'(i); tick(); end
      checks++; if (tr_count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL fill16 cnt=%0d ovf=%0b exp 16/0", tr_count, overflow); end
      mem_write = 1; wb_data = 8'hA5; mem_data = 8'h3C; tr_ready = 1;
      tick();
      reg_write = 0; mem_write = 0;
      checks++; if (tr_count !== 5'd16 || overflow !== 1'b0) begin failures++; $display("FAIL full_pushpop cnt=%0d ovf=%0b exp 16/0", tr_count, overflow); end
      repeat (15) tick();
      h = tr_data;
      checks++; if (tr_count !== 5'd1 || h[DATA_W+PC_W +: 2] !== 2'b11 || h[DATA_W-1:0] !== 8'hA5 || h[EW-1 -: CYC_W] !== 16'd16) begin
         failures++; $display("FAIL kind_entry cnt=%0d kind=%b data=%h cyc=%0d exp 1/11/a5/16", tr_count, h[DATA_W+PC_W +: 2], h[DATA_W-1:0], h[EW-1 -: CYC_W]); end
      tick();
      checks++; if (tr_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", tr_valid); end
      tick();
      checks++; if (tr_count !== 5'd0) begin failures++; $display("FAIL pop_empty cnt=%0d exp=0", tr_count); end
      tr_ready = 0;
   endtask

   task automatic test_async_reset();
      max_cycles = 0; bp_en = 0; tr_ready = 0;
      start = 1; tick(); start = 0;
      reg_write = 1;
      repeat (6) tick();
      checks++; if (tr_count !== 5'd6) begin failures++; $display("FAIL pre_rst_cnt got=%0d exp=6", tr_count); end
      #2 rst = 1'b1;
      #1;
      checks++; if (cpu_en !== 1'b0) begin failures++; $display("FAIL async_rst_en got=%0b exp=0", cpu_en); end
      @(posedge clk); @(negedge clk);
      checks++; if ({running, halted, halt_cause, tr_valid, overflow} !== 6'b0 || tr_count !== 5'd0 || cycle_count !== 16'd0 || tr_data !== '0) begin
         failures++; $display("FAIL async_rst_outs run=%0b halt=%0b cause=%b v=%0b ovf=%0b cnt=%0d cyc=%0d exp all 0",
                              running, halted, halt_cause, tr_valid, overflow, tr_count, cycle_count); end
      rst = 1'b0; reg_write = 0;
      model_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         start  = (i == 0) || ($urandom_range(0, 39) == 0);
         resume = ($urandom_range(0, 5) == 0);
         step   = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 19) == 0) max_cycles = 16'($urandom_range(0, 12));
         bp_en     = ($urandom_range(0, 3) == 0);
         bp_pc     = 8'($urandom_range(0, 15));
         pc        = 8'($urandom_range(0, 15));
         reg_write = 1'($urandom);
         mem_write = 1'($urandom);
         wb_data   = 8'($urandom);
         mem_data  = 8'($urandom);
         tr_ready  = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (cpu_en !== exp_en()) begin failures++; $display("FAIL rnd_cpu_en i=%0d got=%0b exp=%0b", i, cpu_en, exp_en()); end
         tick();
         checks++; if (running !== (m_state == 1 || m_state == 2) || halted !== (m_state == 3)) begin
            failures++; $display("FAIL rnd_state i=%0d run=%0b halt=%0b exp_state=%0d", i, running, halted, m_state); end
         if (m_state == 3) begin
            checks++; if (halt_cause !== 2'(m_cause)) begin failures++; $display("FAIL rnd_cause i=%0d got=%b exp=%0d", i, halt_cause, m_cause); end
         end
         checks++; if (cycle_count !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cycle i=%0d got=%0d exp=%0d", i, cycle_count, m_cnt); end
         checks++; if (tr_count !== 5'(m_q.size()) || tr_valid !== (m_q.size() != 0) || overflow !== m_ovf) begin
            failures++; $display("FAIL rnd_fifo i=%0d cnt=%0d v=%0b ovf=%0b exp %0d/%0b", i, tr_count, tr_valid, overflow, m_q.size(), m_ovf); end
         if (m_q.size() != 0) begin
            checks++; if (tr_data !== m_q[0]) begin failures++; $display("FAIL rnd_head i=%0d got=%h exp=%h", i, tr_data, m_q[0]); end
         end
      end
      start = 0; resume = 0; step = 0; reg_write = 0; mem_write = 0;
   endtask

   initial begin
      test_reset();
      test_limit();
      test_breakpoint();
      test_step();
      test_overflow();
      test_kind_and_full_pushpop();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout sim_time=%0t exp=finish_before_limit", $time);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mini_proc_run_ctrl.md
# mini_proc_run_ctrl

Parametrised run controller and write-back trace buffer for the single-cycle mini processor. It gates the processor through a clock-enable, runs it for a programmable number of cycles, halts on a PC breakpoint, supports single-step and resume, and records every register or data-memory write into a circular trace FIFO. The FIFO is drained over a valid/ready port. It replaces fixed-delay run-then-stop stimulus with an on-chip, reusable harness.

## Interface
- DATA_W, 8: write-back and memory data width
- PC_W, 8: program counter width
- CYC_W, 16: cycle counter width
- DEPTH, 16: trace entries, power of two, ≥2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse: clear counter and trace, enter RUN
- resume  in  1  pulse: HALT→RUN, counter and trace kept
- step  in  1  pulse: HALT→STEP, exactly one enabled cycle
- max_cycles  in  CYC_W  cycle limit; 0 = unlimited
- bp_en  in  1  breakpoint enable
- bp_pc  in  PC_W  breakpoint address
- pc  in  PC_W  processor current PC
- reg_write  in  1  processor register-file write this cycle
- mem_write  in  1  processor data-memory write this cycle
- wb_data  in  DATA_W  register write-back data
- mem_data  in  DATA_W  data-memory write data
- cpu_en  out  1  processor clock-enable
- running  out  1  state is RUN or STEP
- halted  out  1  state is HALT
- halt_cause  out  2  01 limit, 10 breakpoint, 11 step done, 00 none
- cycle_count  out  CYC_W  enabled cycles since last start
- tr_valid  out  1  trace FIFO not empty
- tr_data  out  CYC_W+2+PC_W+DATA_W  head entry {cycle, kind, pc, data}
- tr_ready  in  1  consumer accepts head
- tr_count  out  log2(DEPTH)+1  entries held
- overflow  out  1  sticky: an entry was overwritten

## Operation
- States: IDLE, RUN, STEP, HALT. Reset → IDLE.
- cpu_en is combinational: 1 in STEP; 1 in RUN unless bp_hit; else 0.
- bp_hit = bp_en & (pc == bp_pc) & RUN & !skip_bp. skip_bp is set for the first RUN cycle after resume and cleared after it.
- IDLE: start → RUN. Other inputs are ignored.
- RUN:
  - bp_hit → HALT, cause 10. No enabled cycle occurs.
  - Else, if max_cycles≠0 and cycle_count+1 == max_cycles → HALT, cause 01 after this enabled cycle.
- STEP: one enabled cycle, then HALT with cause 11. Breakpoint and limit are not checked.
- HALT:
  - start → RUN with a full clear.
  - resume → RUN.
  - step → STEP.
  - Priority: start > resume > step.
- start in any state restarts the run: cycle_count=0, trace emptied, overflow=0, cause=00, next state RUN.
- cycle_count increments on every edge where cpu_en=1. It saturates at all-ones.
- Capture: on an edge with cpu_en=1 and (reg_write|mem_write), push one entry.
  - Fields: cycle = pre-increment cycle_count, kind = {mem_write, reg_write}, pc.
  - data = wb_data when reg_write=1, else mem_data.
- FIFO is a circular buffer with wrapping read/write pointers.
  - Pop on tr_valid & tr_ready.
  - Push when full with no pop: oldest entry is dropped (read pointer advances), overflow is set, tr_count stays DEPTH.
  - Push and pop in the same cycle: tr_count unchanged, never an overflow.
  - Pop when empty is ignored.
- tr_data is valid only while tr_valid=1. It is the registered head entry, held stable until popped.

## Timing
- Reset values: state IDLE, cpu_en=0, running=0, halted=0, halt_cause=00, cycle_count=0, tr_valid=0, tr_count=0, overflow=0, tr_data=0.
- start sampled at edge N → RUN from N; cpu_en=1 in cycle N+1 unless bp_hit.
- A run with max_cycles=M gives exactly M cpu_en cycles. halted=1 in the cycle after the M-th.
- Breakpoint: cpu_en drops in the same cycle the PC matches. halted=1 from the next edge.
- A captured entry is visible on tr_valid one cycle after its enabled edge.
- An asynchronous rst mid-run forces cpu_en=0 immediately and discards the trace.

## Test plan
- Reset, then start with max_cycles=5 and bp_en=0 → cpu_en high exactly 5 cycles; halted=1; halt_cause=01; cycle_count=5.
- bp_en=1, bp_pc=0x03, PC advancing 0,1,2,3 → cpu_en=0 while pc=3; halt_cause=10; cycle_count=3. Then resume → pc=3 executes and the run continues.
- In HALT, pulse step three times → three single enabled cycles, each ending with halt_cause=11; cycle_count +3.
- reg_write every cycle, DEPTH=16, 20 cycles, tr_ready=0 → tr_count=16; overflow=1; first entry popped has cycle=4.
- reg_write=mem_write=1 with wb_data=0xA5, mem_data=0x3C → entry kind=11, data=0xA5. Push and pop in one cycle while full → tr_count unchanged, overflow not newly set.
- Assert rst mid-RUN with 6 entries held → next cycle: IDLE, tr_count=0, cpu_en=0, all outputs at reset values.
